// File: rtl/clk_lock_supervisor.sv
// Clock-lock supervisor: pulses the PLL/DCM reset, waits for a stable synchronized
// lock, then releases the memory, bus and IO domain resets in order.
module clk_lock_supervisor #(
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 64
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       lock_i,
    output logic       pll_rst_o,
    output logic [2:0] stage_rst_o,
    output logic       ready_o,
    output logic [2:0] state_o,
    output logic [7:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // RELEASE runs for 2*STAGE_GAP+1 cycles, so it competes with the other limits
    localparam int REL_LEN = 2 * STAGE_GAP + 1;
    localparam int MAX_CNT = max2(max2(RST_PULSE, LOCK_TIMEOUT), max2(SETTLE_CYCLES, REL_LEN));
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP1_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] GAP2_LAST    = CNT_W'(2 * STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'(2 * STAGE_GAP);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_s;

    assign state_o = state;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            lock_meta   <= 1'b0;
            lock_s      <= 1'b0;
            state       <= PLL_RST;
            cnt         <= '0;
            pll_rst_o   <= 1'b1;
            stage_rst_o <= 3'b111;
            ready_o     <= 1'b0;
            retry_cnt_o <= 8'd0;
            loss_cnt_o  <= 8'd0;
        end else begin
            lock_meta <= lock_i;
            lock_s    <= lock_meta;
            case (state)
                PLL_RST: begin
                    pll_rst_o   <= 1'b1;
                    stage_rst_o <= 3'b111;
                    ready_o     <= 1'b0;
                    if (cnt == RST_LAST) begin
                        state     <= WAIT_LOCK;
                        pll_rst_o <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state     <= PLL_RST;
                        pll_rst_o <= 1'b1;
                        cnt       <= '0;
                        if (retry_cnt_o != 8'hFF)
                            retry_cnt_o <= retry_cnt_o + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == SETTLE_LAST) begin
                        // bit0 is already clear when RELEASE first becomes visible
                        state       <= RELEASE;
                        stage_rst_o <= 3'b110;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state       <= PLL_RST;
                        pll_rst_o   <= 1'b1;
                        stage_rst_o <= 3'b111;
                        ready_o     <= 1'b0;
                        cnt         <= '0;
                    end else if (cnt == REL_LAST) begin
                        state   <= RUN;
                        ready_o <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == GAP1_LAST)
                            stage_rst_o <= 3'b100;
                        else if (cnt == GAP2_LAST)
                            stage_rst_o <= 3'b000;
                    end
                end
                RUN: begin
                    stage_rst_o <= 3'b000;
                    if (!lock_s) begin
                        state       <= PLL_RST;
                        pll_rst_o   <= 1'b1;
                        stage_rst_o <= 3'b111;
                        ready_o     <= 1'b0;
                        cnt         <= '0;
                        if (loss_cnt_o != 8'hFF)
                            loss_cnt_o <= loss_cnt_o + 8'd1;
                    end
                end
                default: begin
                    state       <= PLL_RST;
                    pll_rst_o   <= 1'b1;
                    stage_rst_o <= 3'b111;
                    ready_o     <= 1'b0;
                    cnt         <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Scoreboard bench for clk_lock_supervisor: every output change is an event whose
// dwell time (cycles since the previous change) and output values are predicted.
module tb_clk_lock_supervisor;

    localparam int RST_PULSE     = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int SETTLE_CYCLES = 16;
    localparam int STAGE_GAP     = 8;

    localparam int S_PLL_RST = 0;
    localparam int S_WAIT    = 1;
    localparam int S_SETTLE  = 2;
    localparam int S_RELEASE = 3;
    localparam int S_RUN     = 4;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i;
    logic       lock_i;
    logic       pll_rst_o;
    logic [2:0] stage_rst_o;
    logic       ready_o;
    logic [2:0] state_o;
    logic [7:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;

    always #5 wb_clk_i = ~wb_clk_i;

    clk_lock_supervisor #(
        .RST_PULSE    (RST_PULSE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .STAGE_GAP    (STAGE_GAP)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .lock_i     (lock_i),
        .pll_rst_o  (pll_rst_o),
        .stage_rst_o(stage_rst_o),
        .ready_o    (ready_o),
        .state_o    (state_o),
        .retry_cnt_o(retry_cnt_o),
        .loss_cnt_o (loss_cnt_o)
    );

    typedef struct packed {
        logic [15:0] dwell;
        logic [2:0]  state;
        logic        pll;
        logic [2:0]  stage;
        logic        ready;
        logic [7:0]  retry;
        logic [7:0]  loss;
    } ev_t;

    ev_t exp_q[$];
    int  n_compared   = 0;
    int  n_mismatched = 0;
    int  cyc          = 0;
    int  ev_idx       = 0;
    bit  mon_en       = 1'b0;

    always @(posedge wb_clk_i) cyc++;

    function automatic ev_t mk(input int dwell, input int st, input logic pll,
                               input logic [2:0] stg, input logic rdy,
                               input int rty, input int los);
        ev_t e;
        e.dwell = 16'(dwell);
        e.state = 3'(st);
        e.pll   = pll;
        e.stage = stg;
        e.ready = rdy;
        e.retry = 8'(rty);
        e.loss  = 8'(los);
        return e;
    endfunction

    function automatic string fmt(input ev_t e);
        return $sformatf("dwell=%0d state=%0d pll=%0b stage=%03b ready=%0b retry=%0d loss=%0d",
                         e.dwell, e.state, e.pll, e.stage, e.ready, e.retry, e.loss);
    endfunction

    function automatic ev_t snap(input int dwell);
        return mk(dwell, int'(state_o), pll_rst_o, stage_rst_o, ready_o,
                  int'(retry_cnt_o), int'(loss_cnt_o));
    endfunction

    task automatic push_ev(input int dwell, input int st, input logic pll,
                           input logic [2:0] stg, input logic rdy,
                           input int rty, input int los);
        exp_q.push_back(mk(dwell, st, pll, stg, rdy, rty, los));
    endtask

    // Staged release after a full settle, ending in RUN
    task automatic push_release(input int rty, input int los);
        push_ev(16, S_RELEASE, 1'b0, 3'b110, 1'b0, rty, los);
        push_ev(8,  S_RELEASE, 1'b0, 3'b100, 1'b0, rty, los);
        push_ev(8,  S_RELEASE, 1'b0, 3'b000, 1'b0, rty, los);
        push_ev(1,  S_RUN,     1'b0, 3'b000, 1'b1, rty, los);
    endtask

    // Lock raised just before WAIT_LOCK entry: synchronizer makes WAIT_LOCK last 2 cycles
    task automatic push_recover(input int rty, input int los);
        push_ev(4, S_WAIT,   1'b0, 3'b111, 1'b0, rty, los);
        push_ev(2, S_SETTLE, 1'b0, 3'b111, 1'b0, rty, los);
        push_release(rty, los);
    endtask

    task automatic check_output(input ev_t act);
        ev_t e;
        n_compared++;
        if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL unexpected_event_%0d: got %s, required no change", ev_idx, fmt(act));
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_mismatched++;
                $display("[TB] FAIL event_%0d @cyc %0d: got %s, required %s", ev_idx, cyc, fmt(act), fmt(e));
            end
        end
        ev_idx++;
    endtask

    task automatic wait_state(input int st, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge wb_clk_i);
            if (state_o == 3'(st)) return;
        end
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL wait_state: state_o=%0d after %0d cycles, required %0d", state_o, budget, st);
    endtask

    task automatic recover_lock();
        wait_state(S_PLL_RST, 20);
        repeat (3) @(negedge wb_clk_i);
        lock_i = 1'b1;
    endtask

    // Called on the first negedge of RUN; RUN lasts 3 cycles after lock_i falls
    task automatic apply_stimulus(input int rty, input int los_after);
        lock_i = 1'b0;
        push_ev(3, S_PLL_RST, 1'b1, 3'b111, 1'b0, rty, los_after);
        push_recover(rty, los_after);
        recover_lock();
        wait_state(S_RUN, 100);
    endtask

    // Monitor: compares every change of the output vector against the scoreboard
    initial begin
        ev_t prev;
        ev_t cur;
        int  last;
        wait (mon_en);
        prev = snap(0);
        last = cyc;
        check_output(prev);
        forever begin
            @(negedge wb_clk_i);
            cur = snap(0);
            if (cur !== prev) begin
                check_output(snap(cyc - last));
                prev = cur;
                last = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        wb_rst_i = 1'b1;
        lock_i   = 1'b1;
        repeat (3) @(negedge wb_clk_i);

        // Reset release with lock held; one-cycle dropout at SETTLE cycle 10
        push_ev(0,  S_PLL_RST, 1'b1, 3'b111, 1'b0, 0, 0);
        push_ev(4,  S_WAIT,    1'b0, 3'b111, 1'b0, 0, 0);
        push_ev(1,  S_SETTLE,  1'b0, 3'b111, 1'b0, 0, 0);
        push_ev(13, S_WAIT,    1'b0, 3'b111, 1'b0, 0, 0);
        push_ev(1,  S_SETTLE,  1'b0, 3'b111, 1'b0, 0, 0);
        push_release(0, 0);
        mon_en   = 1'b1;
        wb_rst_i = 1'b0;
        $display("[TB] reset release, lock held, settle glitch");
        wait_state(S_SETTLE, 50);
        repeat (10) @(negedge wb_clk_i);
        lock_i = 1'b0;
        @(negedge wb_clk_i);
        lock_i = 1'b1;
        wait_state(S_RUN, 100);

        $display("[TB] lock loss in RUN");
        apply_stimulus(0, 1);

        // Lock loss between bit0 and bit1 release: no loss count
        $display("[TB] lock loss during RELEASE");
        lock_i = 1'b0;
        push_ev(3,  S_PLL_RST, 1'b1, 3'b111, 1'b0, 0, 2);
        push_ev(4,  S_WAIT,    1'b0, 3'b111, 1'b0, 0, 2);
        push_ev(2,  S_SETTLE,  1'b0, 3'b111, 1'b0, 0, 2);
        push_ev(16, S_RELEASE, 1'b0, 3'b110, 1'b0, 0, 2);
        push_ev(5,  S_PLL_RST, 1'b1, 3'b111, 1'b0, 0, 2);
        push_recover(0, 2);
        recover_lock();
        wait_state(S_RELEASE, 50);
        repeat (2) @(negedge wb_clk_i);
        lock_i = 1'b0;
        recover_lock();
        wait_state(S_RUN, 100);

        $display("[TB] wb_rst_i pulse in RUN");
        wb_rst_i = 1'b1;
        push_ev(1, S_PLL_RST, 1'b1, 3'b111, 1'b0, 0, 0);
        push_ev(4, S_WAIT,    1'b0, 3'b111, 1'b0, 0, 0);
        push_ev(1, S_SETTLE,  1'b0, 3'b111, 1'b0, 0, 0);
        push_release(0, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        wait_state(S_RUN, 100);

        // Reset, then no lock for 350 cycles: three timeouts
        $display("[TB] lock absent for 350 cycles");
        wb_rst_i = 1'b1;
        lock_i   = 1'b0;
        push_ev(1,   S_PLL_RST, 1'b1, 3'b111, 1'b0, 0, 0);
        push_ev(4,   S_WAIT,    1'b0, 3'b111, 1'b0, 0, 0);
        push_ev(100, S_PLL_RST, 1'b1, 3'b111, 1'b0, 1, 0);
        push_ev(4,   S_WAIT,    1'b0, 3'b111, 1'b0, 1, 0);
        push_ev(100, S_PLL_RST, 1'b1, 3'b111, 1'b0, 2, 0);
        push_ev(4,   S_WAIT,    1'b0, 3'b111, 1'b0, 2, 0);
        push_ev(100, S_PLL_RST, 1'b1, 3'b111, 1'b0, 3, 0);
        push_ev(4,   S_WAIT,    1'b0, 3'b111, 1'b0, 3, 0);
        push_ev(37,  S_SETTLE,  1'b0, 3'b111, 1'b0, 3, 0);
        push_release(3, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (350) @(negedge wb_clk_i);
        lock_i = 1'b1;
        wait_state(S_RUN, 100);

        $display("[TB] 300 lock losses in RUN");
        for (int i = 1; i <= 300; i++)
            apply_stimulus(3, (i > 255) ? 255 : i);

        repeat (20) @(negedge wb_clk_i);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL missing_event: got no change, required %s", fmt(e));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
